// File: rtl/seq_divider_pkg.sv
// Common types for the sequential restoring divider.
`include "seq_divider_defs.vh"

package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = `SEQ_DIVIDER_IDLE,
    RUN  = `SEQ_DIVIDER_RUN,
    DONE = `SEQ_DIVIDER_DONE
  } state_t;

  // Step counter must hold the value N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/addern.sv
// Generic N-bit ripple adder with carry in and carry out.
module addern #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/seq_divider_defs.vh
// Shared FSM state encodings for the sequential divider.
`ifndef SEQ_DIVIDER_DEFS_VH
`define SEQ_DIVIDER_DEFS_VH
`define SEQ_DIVIDER_IDLE 2'b00
`define SEQ_DIVIDER_RUN  2'b01
`define SEQ_DIVIDER_DONE 2'b10
`endif

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step built on a shared N+1-bit adder.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] rem,
  input  logic         msb,
  input  logic [N-1:0] dvs,
  output logic [N-1:0] rem_nxt,
  output logic         qbit
);

  logic [N:0] shifted;
  logic [N:0] diff;
  logic       cout;

  assign shifted = {rem, msb};

  addern #(.N(N + 1)) u_add (
    .a    (shifted),
    .b    (~{1'b0, dvs}),
    .cin  (1'b1),
    .s    (diff),
    .cout (cout)
  );

  // The partial remainder stays below the divisor, so a kept difference
  // never has its top bit set; folding it in costs nothing.
  assign qbit    = cout & ~diff[N];
  assign rem_nxt = qbit ? diff[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Define SEQ_DIVIDER_DBZ_EN to short-circuit divide-by-zero with a dbz flag.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dbz
);

  localparam int CW = cnt_width(N);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q_r;
  logic [N-1:0]  r_r;
  logic [N-1:0]  d_r;
  logic [N-1:0]  rem_nxt;
  logic          qbit;
  logic          accept;
  logic          zero_div;

  assign accept = start && (state != RUN);

`ifdef SEQ_DIVIDER_DBZ_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)      state_nxt = zero_div ? DONE : RUN;
        else            state_nxt = IDLE;
      end
      RUN: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      default:          state_nxt = IDLE;
    endcase
  end

  div_step #(.N(N)) u_step (
    .rem     (r_r),
    .msb     (q_r[N-1]),
    .dvs     (d_r),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // Dividend shifts out of q_r as quotient bits shift in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
      cnt <= '0;
    end else if (accept) begin
      d_r <= divisor;
      if (zero_div) begin
        q_r <= '1;
        r_r <= dividend;
        cnt <= '0;
      end else begin
        q_r <= dividend;
        r_r <= '0;
        cnt <= CW'(N);
      end
    end else if (state == RUN) begin
      q_r <= {q_r[N-2:0], qbit};
      r_r <= rem_nxt;
      cnt <= cnt - CW'(1);
    end
  end

`ifdef SEQ_DIVIDER_DBZ_EN
  logic dbz_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       dbz_r <= 1'b0;
    else if (accept) dbz_r <= zero_div;
  end

  assign dbz = dbz_r;
`else
  assign dbz = 1'b0;
`endif

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign quotient  = q_r;
  assign remainder = r_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: directed cases plus random traffic against a timeline model.
module tb_seq_divider;

  localparam int N = 4;
`ifdef SEQ_DIVIDER_DBZ_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, dbz;
  logic [N-1:0] quotient, remainder;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: cycle index = number of active edges seen since reset release.
  int cyc = 0;
  int acc_c = -100;
  int done_c = -100;
  bit skip = 1'b0;
  int pq = 0, pr = 0, pdbz = 0;
  int eq = 0, er = 0, edbz = 0;
  bit chk_en = 1'b0;

  function automatic bit m_busy(input int c);
    return !skip && (c >= acc_c) && (c < done_c);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_c = -100; done_c = -100; skip = 1'b0;
      eq = 0; er = 0; edbz = 0;
    end else begin
      cyc++;
      if (start && !m_busy(cyc - 1)) begin
        acc_c  = cyc;
        skip   = DBZ_EN && (divisor == 0);
        done_c = skip ? cyc : cyc + N;
        if (divisor != 0) begin
          pq = int'(dividend) / int'(divisor);
          pr = int'(dividend) % int'(divisor);
        end else begin
          pq = (1 << N) - 1;
          pr = int'(dividend);
        end
        pdbz = skip;
      end
      if (cyc == done_c) begin
        eq = pq; er = pr; edbz = pdbz;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("busy", busy, m_busy(cyc));
      check("done", done, (cyc == done_c));
      if (!m_busy(cyc)) begin
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("dbz", dbz, edbz);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic launch(input int dd, input int dv);
    dividend = N'(dd);
    divisor  = N'(dv);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done; exp_lat/exp_nbusy < 0 means "do not check".
  task automatic wait_result(input string tag, input int exp_q, input int exp_r,
                             input int exp_dbz, input int exp_lat, input int exp_nbusy);
    int k, nb;
    bit seen;
    k = 0; nb = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
      else if (busy) nb++;
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, done, 1);
    end else begin
      if (exp_lat >= 0)   check({tag, "_lat"}, k, exp_lat);
      if (exp_nbusy >= 0) check({tag, "_busy_cycles"}, nb, exp_nbusy);
      check({tag, "_q"}, quotient, exp_q);
      check({tag, "_r"}, remainder, exp_r);
      check({tag, "_dbz"}, dbz, exp_dbz);
    end
  endtask

  task automatic run_div(input string tag, input int dd, input int dv, input int exp_q,
                         input int exp_r, input int exp_dbz, input int exp_lat,
                         input int exp_nbusy);
    launch(dd, dv);
    wait_result(tag, exp_q, exp_r, exp_dbz, exp_lat, exp_nbusy);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", dbz, 0);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    idle(1);

    run_div("d13_3", 13, 3, 4, 1, 0, N + 1, N);
    idle(2);
    run_div("d15_1", 15, 1, 15, 0, 0, N + 1, N);
    idle(1);
    run_div("d2_7", 2, 7, 0, 2, 0, N + 1, N);
    idle(1);
    run_div("d9_0", 9, 0, 15, 9, int'(DBZ_EN), DBZ_EN ? 1 : N + 1, DBZ_EN ? 0 : N);
    idle(2);

    // Second start during RUN must be ignored.
    launch(13, 3);
    @(posedge clk);
    #1;
    dividend = N'(6); divisor = N'(2); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_result("ign6_2", 4, 1, 0, -1, -1);
    idle(2);

    // Asynchronous reset in the second RUN cycle.
    launch(13, 3);
    @(posedge clk);
    #2;
    check("r34_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("r34_busy", busy, 0);
    check("r34_done", done, 0);
    check("r34_q", quotient, 0);
    check("r34_r", remainder, 0);
    check("r34_dbz", dbz, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (N + 3) begin
      @(negedge clk);
      check("r34_no_done", done, 0);
    end
    #1;
    run_div("d12_5", 12, 5, 2, 2, 0, N + 1, N);
    idle(1);

    // Back-to-back: start issued during the DONE cycle.
    run_div("b2b13_3", 13, 3, 4, 1, 0, N + 1, N);
    #1;
    run_div("b2b10_4", 10, 4, 2, 2, 0, N + 1, N);
    idle(2);

    // Random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      #1;
      start    = ($urandom_range(0, 3) == 0);
      dividend = N'($urandom_range(0, (1 << N) - 1));
      divisor  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        #1;
        check("rnd_rst_busy", busy, 0);
        check("rnd_rst_done", done, 0);
        check("rnd_rst_q", quotient, 0);
        check("rnd_rst_r", remainder, 0);
        #1 reset = 1'b0;
      end
    end
    start = 1'b0;
    idle(N + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits; legal values are 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 SHALL have port dividend, input, N bits: unsigned dividend, sampled when start is accepted.
REQ-006 SHALL have port divisor, input, N bits: unsigned divisor, sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while the division is iterating.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 SHALL have port quotient, output, N bits: result quotient.
REQ-010 SHALL have port remainder, output, N bits: result remainder.
REQ-011 SHALL have port dbz, output, 1 bit: divide-by-zero flag, valid alongside done.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance it latches both operands, clears the partial remainder, loads a step counter with N, and enters RUN.
REQ-014 SHALL ignore start while in RUN, leaving the operands and the operation in progress unaffected.
REQ-015 SHALL, in RUN, perform one restoring step per cycle:
- shift the next dividend MSB into the partial remainder;
- subtract the divisor using one shared N+1-bit adder (carry-in 1, divisor inverted);
- on carry-out 1, keep the difference and shift in quotient bit 1;
- otherwise restore the remainder and shift in quotient bit 0.
REQ-016 SHALL decrement the step counter each RUN cycle and move to DONE after exactly N RUN cycles.
REQ-017 SHALL assert busy exactly during RUN.
REQ-018 SHALL assert done exactly during DONE, which lasts one cycle before returning to IDLE unless start is accepted.
REQ-019 SHALL produce done with a latency of N+1 cycles after the edge that accepts start.
REQ-020 SHALL hold quotient, remainder and dbz stable from DONE until the next accepted start.
REQ-021 SHALL, for divisor ≠ 0, guarantee dividend = quotient·divisor + remainder with remainder < divisor.

Reset
REQ-022 SHALL, on reset, immediately force the FSM to IDLE regardless of the clock, including mid-RUN.
REQ-023 SHALL, on reset, clear busy, done, dbz, quotient, remainder and the step counter to 0.
REQ-024 SHALL discard any division interrupted by reset; no done pulse follows it.

Configuration
REQ-025 SHALL honour the macro SEQ_DIVIDER_DBZ_EN.
REQ-026 SHALL, when SEQ_DIVIDER_DBZ_EN is defined and divisor = 0 at start:
- skip RUN and enter DONE on the next cycle (latency 1);
- set dbz=1, quotient = all ones, remainder = dividend.
REQ-027 SHALL, when SEQ_DIVIDER_DBZ_EN is not defined:
- tie dbz to 0;
- run divisor = 0 through the normal N steps, which yields quotient all ones and remainder = dividend after N+1 cycles.

Structure
REQ-028 SHALL take the FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) from the shared definitions file seq_divider_defs.vh.
REQ-029 SHALL contain one sub-module, div_step: the combinational restoring step built from the existing addern (N+1 bits), with outputs next remainder and quotient bit.

Verification (N=4)
REQ-030 SHALL verify: start with 13/3 -> busy for 4 cycles, done at cycle 5, quotient=4, remainder=1, dbz=0.
REQ-031 SHALL verify: 15/1 -> quotient=15, remainder=0; then 2/7 -> quotient=0, remainder=2.
REQ-032 SHALL verify: 9/0 with SEQ_DIVIDER_DBZ_EN -> done at cycle 1, dbz=1, quotient=15, remainder=9; without the macro -> done at cycle 5, dbz=0, same values.
REQ-033 SHALL verify: start 13/3, then start 6/2 during RUN -> the second request is ignored and the result is quotient=4, remainder=1.
REQ-034 SHALL verify: reset asserted in the 2nd RUN cycle -> all outputs are 0 immediately and no done pulse follows; a subsequent 12/5 -> quotient=2, remainder=2.
REQ-035 SHALL verify: start asserted in the DONE cycle with 10/4 -> back-to-back accept, next done 5 cycles later, quotient=2, remainder=2.
